// File: rtl/rtc_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// rtc_cmd_arbiter
//
// Shares the RTC control inputs (ToD load, period load, precise adjust, offset
// load) between the host register interface (i_h_*) and the PTP servo (i_s_*).
// Queued commands are granted round-robin, each command produces exactly one
// load pulse, and precise adjustments are sequenced through the rtc's
// adj_ld_done handshake. Every command ends with one o_done pulse carrying the
// requester id and an error flag (ADJ never armed / timed out).
//
// Parameters
//   SETTLE_CYC   idle cycles after a TIME/PERIOD/OFFSET pulse (1..15)
//   ARM_CYC      max cycles to wait for adj_ld_done to fall after adj_ld
//   ADJ_TIMEOUT  max cycles in WAIT_DONE before the adjustment is abandoned
//
// Ports
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_h_valid/o_h_ready/i_h_op/i_h_data   host command channel
//   i_s_valid/o_s_ready/i_s_op/i_s_data   servo command channel
//     op: 0 TIME, 1 PERIOD, 2 ADJ, 3 OFFSET
//     data: TIME [37:0] ns_frac, [85:38] sec | PERIOD [39:0]
//           ADJ [31:0] cnt, [71:32] period_adj | OFFSET [31:0] ns, [79:32] sec
//   o_time_ld/o_period_ld/o_adj_ld/o_offset_ld   one-cycle load pulses
//   o_time_reg_ns_in, o_time_reg_sec_in, o_period_in, o_adj_ld_data,
//   o_period_adj, o_offset_ptp_ns_in, o_offset_ptp_sec_in
//                                 registered rtc operands, hold last value
//   i_adj_ld_done                 from rtc, high when no adjustment pending
//   o_done/o_done_id/o_done_err   completion pulse, 0 host / 1 servo, error
//   o_busy                        high whenever the FSM is not idle
//
// Configuration
//   RTC_CMD_ARB_STATS_EN  adds saturating counters o_stat_h_cnt, o_stat_s_cnt
//                         (completed commands per requester) and o_stat_err_cnt
//                         (completions with error).
// -----------------------------------------------------------------------------
module rtc_cmd_arbiter #(
  parameter int unsigned SETTLE_CYC  = 3,
  parameter int unsigned ARM_CYC     = 4,
  parameter int unsigned ADJ_TIMEOUT = 1048576
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_h_valid,
  output logic        o_h_ready,
  input  logic [1:0]  i_h_op,
  input  logic [95:0] i_h_data,
  input  logic        i_s_valid,
  output logic        o_s_ready,
  input  logic [1:0]  i_s_op,
  input  logic [95:0] i_s_data,
  output logic        o_time_ld,
  output logic        o_period_ld,
  output logic        o_adj_ld,
  output logic        o_offset_ld,
  output logic [37:0] o_time_reg_ns_in,
  output logic [47:0] o_time_reg_sec_in,
  output logic [39:0] o_period_in,
  output logic [31:0] o_adj_ld_data,
  output logic [39:0] o_period_adj,
  output logic [31:0] o_offset_ptp_ns_in,
  output logic [47:0] o_offset_ptp_sec_in,
  input  logic        i_adj_ld_done,
  output logic        o_done,
  output logic        o_done_id,
  output logic        o_done_err,
  output logic        o_busy
`ifdef RTC_CMD_ARB_STATS_EN
  ,
  output logic [15:0] o_stat_h_cnt,
  output logic [15:0] o_stat_s_cnt,
  output logic [15:0] o_stat_err_cnt
`endif
);

  typedef enum logic [1:0] {
    OP_TIME   = 2'd0,
    OP_PERIOD = 2'd1,
    OP_ADJ    = 2'd2,
    OP_OFFSET = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_WAIT_ARM,
    S_WAIT_DONE
  } state_e;

  localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYC - 1);
  localparam logic [31:0] ARM_LAST     = 32'(ARM_CYC - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(ADJ_TIMEOUT - 1);
  localparam logic [39:0] PERIOD_RST   = 40'h8_0000_0000;  // 8 ns, same as rtc reset

  state_e      r_state;
  state_e      w_next;
  logic [31:0] r_cnt;          // cycles spent in the current state
  op_e         r_op;
  logic        r_id;           // requester of the command in flight
  logic        r_last_id;      // requester granted most recently
  logic        r_adj_noop;     // ADJ with cnt all-ones: rtc ignores it

  logic        w_pick_h;
  logic        w_grant;
  op_e         w_sel_op;
  logic [95:0] w_sel_data;
  logic        w_fin;
  logic        w_fin_err;
  logic        w_unused_bits;

  logic        r_time_ld, r_period_ld, r_adj_ld, r_offset_ld;
  logic [37:0] r_time_ns;
  logic [47:0] r_time_sec;
  logic [39:0] r_period;
  logic [31:0] r_adj_cnt;
  logic [39:0] r_period_adj;
  logic [31:0] r_off_ns;
  logic [47:0] r_off_sec;
  logic        r_done, r_done_id, r_done_err;

  // Round-robin: on a tie the requester not served last wins. r_last_id
  // resets to the servo so the host wins the first tie after reset.
  assign w_pick_h   = i_h_valid & (~i_s_valid | r_last_id);
  assign w_grant    = (r_state == S_IDLE) & (i_h_valid | i_s_valid) & ~i_rst;
  assign o_h_ready  = w_grant & w_pick_h;
  assign o_s_ready  = w_grant & ~w_pick_h;
  assign w_sel_op   = op_e'(w_pick_h ? i_h_op : i_s_op);
  assign w_sel_data = w_pick_h ? i_h_data : i_s_data;

  // No command encoding uses the top data bits.
  assign w_unused_bits = ^w_sel_data[95:86];

  always_comb begin
    // NOTE: every output of this block is defaulted first, so no branch can
    // leave one unassigned and infer a latch.
    w_next    = r_state;
    w_fin     = 1'b0;
    w_fin_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (r_op == OP_ADJ && !r_adj_noop) w_next = S_WAIT_ARM;
        else                               w_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_next = S_IDLE;
          w_fin  = 1'b1;
        end
      end
      S_WAIT_ARM: begin
        // rtc drops adj_ld_done once it has taken the adjustment.
        if (!i_adj_ld_done) begin
          w_next = S_WAIT_DONE;
        end else if (r_cnt == ARM_LAST) begin
          w_next    = S_IDLE;
          w_fin     = 1'b1;
          w_fin_err = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        // Completion takes priority over a timeout on the same cycle.
        if (i_adj_ld_done) begin
          w_next = S_IDLE;
          w_fin  = 1'b1;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_next    = S_IDLE;
          w_fin     = 1'b1;
          w_fin_err = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the clock edge, independent of block order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)      r_cnt <= '0;
      else if (r_state != S_IDLE) r_cnt <= r_cnt + 32'd1;
    end
  end

  // Command capture at grant time.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op       <= OP_TIME;
      r_id       <= 1'b0;
      r_last_id  <= 1'b1;
      r_adj_noop <= 1'b0;
    end else if (w_grant) begin
      r_op       <= w_sel_op;
      r_id       <= ~w_pick_h;
      r_last_id  <= ~w_pick_h;
      r_adj_noop <= (w_sel_data[31:0] == 32'hFFFF_FFFF);
    end
  end

  // Operands and pulses are registered on the grant edge so they are
  // presented to the rtc during the ISSUE cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_time_ld    <= 1'b0;
      r_period_ld  <= 1'b0;
      r_adj_ld     <= 1'b0;
      r_offset_ld  <= 1'b0;
      r_time_ns    <= '0;
      r_time_sec   <= '0;
      r_period     <= PERIOD_RST;
      r_adj_cnt    <= '0;
      r_period_adj <= '0;
      r_off_ns     <= '0;
      r_off_sec    <= '0;
    end else begin
      r_time_ld   <= w_grant & (w_sel_op == OP_TIME);
      r_period_ld <= w_grant & (w_sel_op == OP_PERIOD);
      r_adj_ld    <= w_grant & (w_sel_op == OP_ADJ);
      r_offset_ld <= w_grant & (w_sel_op == OP_OFFSET);
      if (w_grant) begin
        case (w_sel_op)
          OP_TIME: begin
            r_time_ns  <= w_sel_data[37:0];
            r_time_sec <= w_sel_data[85:38];
          end
          OP_PERIOD: r_period <= w_sel_data[39:0];
          OP_ADJ: begin
            r_adj_cnt    <= w_sel_data[31:0];
            r_period_adj <= w_sel_data[71:32];
          end
          default: begin
            r_off_ns  <= w_sel_data[31:0];
            r_off_sec <= w_sel_data[79:32];
          end
        endcase
      end
    end
  end

  // Completion pulse lands on the first IDLE cycle after the command.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_done     <= 1'b0;
      r_done_id  <= 1'b0;
      r_done_err <= 1'b0;
    end else begin
      r_done     <= w_fin;
      r_done_id  <= w_fin & r_id;
      r_done_err <= w_fin_err;
    end
  end

`ifdef RTC_CMD_ARB_STATS_EN
  logic [15:0] r_stat_h, r_stat_s, r_stat_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stat_h   <= '0;
      r_stat_s   <= '0;
      r_stat_err <= '0;
    end else if (w_fin) begin
      if (r_id) begin
        if (r_stat_s != 16'hFFFF) r_stat_s <= r_stat_s + 16'd1;
      end else begin
        if (r_stat_h != 16'hFFFF) r_stat_h <= r_stat_h + 16'd1;
      end
      if (w_fin_err && r_stat_err != 16'hFFFF) r_stat_err <= r_stat_err + 16'd1;
    end
  end

  assign o_stat_h_cnt   = r_stat_h;
  assign o_stat_s_cnt   = r_stat_s;
  assign o_stat_err_cnt = r_stat_err;
`endif

  assign o_time_ld           = r_time_ld;
  assign o_period_ld         = r_period_ld;
  assign o_adj_ld            = r_adj_ld;
  assign o_offset_ld         = r_offset_ld;
  assign o_time_reg_ns_in    = r_time_ns;
  assign o_time_reg_sec_in   = r_time_sec;
  assign o_period_in         = r_period;
  assign o_adj_ld_data       = r_adj_cnt;
  assign o_period_adj        = r_period_adj;
  assign o_offset_ptp_ns_in  = r_off_ns;
  assign o_offset_ptp_sec_in = r_off_sec;
  assign o_done              = r_done;
  assign o_done_id           = r_done_id;
  assign o_done_err          = r_done_err;
  assign o_busy              = (r_state != S_IDLE);

endmodule

// File: tb/tb_rtc_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rtc_cmd_arbiter
//
// Directed stimulus for rtc_cmd_arbiter. A timeline model (cycle stamps for
// issue, completion and the idle point) predicts every output each cycle; a
// small rtc model drives adj_ld_done. Literal latencies pin the model.
// -----------------------------------------------------------------------------
module tb_rtc_cmd_arbiter;
  localparam int SETTLE = 3;
  localparam int ARM    = 4;
  localparam int TMO    = 64;
  localparam int INF    = 32'h7FFF_FFFF;
  localparam logic [1:0] OP_TIME = 2'd0, OP_PERIOD = 2'd1, OP_ADJ = 2'd2, OP_OFFSET = 2'd3;

  typedef struct packed {
    logic [1:0]  op;
    logic [95:0] data;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        h_valid = 1'b0, s_valid = 1'b0;
  logic [1:0]  h_op = '0, s_op = '0;
  logic [95:0] h_data = '0, s_data = '0;
  logic        h_ready, s_ready;
  logic        time_ld, period_ld, adj_ld, offset_ld;
  logic [37:0] time_ns;
  logic [47:0] time_sec;
  logic [39:0] period_in;
  logic [31:0] adj_data;
  logic [39:0] period_adj;
  logic [31:0] off_ns;
  logic [47:0] off_sec;
  logic        adj_done = 1'b1;
  logic        done, done_id, done_err, busy;
`ifdef RTC_CMD_ARB_STATS_EN
  logic [15:0] stat_h, stat_s, stat_e;
  int          m_sh, m_ss, m_se;
`endif

  rtc_cmd_arbiter #(
    .SETTLE_CYC (SETTLE),
    .ARM_CYC    (ARM),
    .ADJ_TIMEOUT(TMO)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_h_valid          (h_valid),
    .o_h_ready          (h_ready),
    .i_h_op             (h_op),
    .i_h_data           (h_data),
    .i_s_valid          (s_valid),
    .o_s_ready          (s_ready),
    .i_s_op             (s_op),
    .i_s_data           (s_data),
    .o_time_ld          (time_ld),
    .o_period_ld        (period_ld),
    .o_adj_ld           (adj_ld),
    .o_offset_ld        (offset_ld),
    .o_time_reg_ns_in   (time_ns),
    .o_time_reg_sec_in  (time_sec),
    .o_period_in        (period_in),
    .o_adj_ld_data      (adj_data),
    .o_period_adj       (period_adj),
    .o_offset_ptp_ns_in (off_ns),
    .o_offset_ptp_sec_in(off_sec),
    .i_adj_ld_done      (adj_done),
    .o_done             (done),
    .o_done_id          (done_id),
    .o_done_err         (done_err),
    .o_busy             (busy)
`ifdef RTC_CMD_ARB_STATS_EN
    ,
    .o_stat_h_cnt       (stat_h),
    .o_stat_s_cnt       (stat_s),
    .o_stat_err_cnt     (stat_e)
`endif
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- requester queues and rtc model ----------------
  cmd_t h_q[$];
  cmd_t s_q[$];
  bit   h_acc, s_acc;
  int   rtc_mode = 0;     // 0 behavioural rtc, 1 tied high, 2 tied low
  int   low_at = -1, high_at = -1;

  function automatic cmd_t mk(input logic [1:0] op, input logic [95:0] data);
    cmd_t c;
    c.op   = op;
    c.data = data;
    return c;
  endfunction

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1;
    if (h_acc && h_q.size() > 0) void'(h_q.pop_front());
    if (s_acc && s_q.size() > 0) void'(s_q.pop_front());
    h_valid = (h_q.size() > 0);
    s_valid = (s_q.size() > 0);
    if (h_valid) begin h_op = h_q[0].op; h_data = h_q[0].data; end
    if (s_valid) begin s_op = s_q[0].op; s_data = s_q[0].data; end
    case (rtc_mode)
      0:       adj_done = !(cyc >= low_at && cyc < high_at);
      1:       adj_done = 1'b1;
      default: adj_done = 1'b0;
    endcase
  end

  // rtc: adj_ld_done falls 2 cycles after adj_ld and rises cnt cycles later.
  always @(negedge clk) begin
    if (adj_ld && adj_data != 32'hFFFF_FFFF) begin
      low_at  = cyc + 2;
      high_at = cyc + 2 + int'(adj_data);
    end
  end

  // ---------------- timeline model ----------------
  int          m_free_at, m_issue_at, m_done_at, m_arm_start, m_wait_start;
  bit          m_done_id, m_done_err, m_last, m_iss_id, m_adj_act;
  logic [1:0]  m_iss_op;
  logic [95:0] m_iss_data;
  logic [37:0] e_tns;
  logic [47:0] e_tsec;
  logic [39:0] e_per;
  logic [31:0] e_adj;
  logic [39:0] e_padj;
  logic [31:0] e_ons;
  logic [47:0] e_osec;

  task automatic m_reset();
    m_free_at = 0; m_issue_at = -1; m_done_at = -1; m_adj_act = 0; m_last = 1;
    e_tns = '0; e_tsec = '0; e_per = 40'h8_0000_0000; e_adj = '0; e_padj = '0;
    e_ons = '0; e_osec = '0;
`ifdef RTC_CMD_ARB_STATS_EN
    m_sh = 0; m_ss = 0; m_se = 0;
`endif
  endtask

  task automatic m_finish(input bit err);
    m_done_at  = cyc + 1;
    m_done_id  = m_iss_id;
    m_done_err = err;
    m_free_at  = cyc + 1;
    m_adj_act  = 0;
  endtask

  bit   grant_log[$];
  int   last_grant_cyc = 0, last_done_cyc = 0, n_done_seen = 0;
  logic last_done_id = 1'b0, last_done_err = 1'b0;

  always @(negedge clk) begin
    logic       e_busy, e_hr, e_sr, e_done, e_did, e_derr;
    logic [3:0] e_ld;
    bit         pick;
    e_hr = 0; e_sr = 0; e_ld = '0; e_done = 0; e_did = 0; e_derr = 0; e_busy = 0;
    h_acc = h_valid & h_ready;
    s_acc = s_valid & s_ready;
    if (h_acc) begin grant_log.push_back(1'b0); last_grant_cyc = cyc; end
    if (s_acc) begin grant_log.push_back(1'b1); last_grant_cyc = cyc; end
    if (done) begin
      n_done_seen++;
      last_done_cyc = cyc; last_done_id = done_id; last_done_err = done_err;
    end
    if (rst) begin
      m_reset();
    end else begin
      e_busy = (cyc < m_free_at);
      if (m_adj_act && cyc >= m_arm_start) begin
        if (m_wait_start < 0) begin
          if (!adj_done) m_wait_start = cyc + 1;
          else if (cyc == m_arm_start + ARM - 1) m_finish(1'b1);
        end else if (adj_done) m_finish(1'b0);
        else if (cyc == m_wait_start + TMO - 1) m_finish(1'b1);
      end
      if (cyc == m_done_at) begin
        e_done = 1; e_did = m_done_id; e_derr = m_done_err;
`ifdef RTC_CMD_ARB_STATS_EN
        if (m_done_id) m_ss++; else m_sh++;
        if (m_done_err) m_se++;
`endif
      end
      if (cyc == m_issue_at) begin
        e_ld[m_iss_op] = 1'b1;
        case (m_iss_op)
          OP_TIME:   begin e_tns = m_iss_data[37:0]; e_tsec = m_iss_data[85:38]; end
          OP_PERIOD: e_per = m_iss_data[39:0];
          OP_ADJ:    begin e_adj = m_iss_data[31:0]; e_padj = m_iss_data[71:32]; end
          default:   begin e_ons = m_iss_data[31:0]; e_osec = m_iss_data[79:32]; end
        endcase
      end
      if (!e_busy && (h_valid || s_valid)) begin
        pick = !(h_valid && (!s_valid || m_last));
        if (pick) begin e_sr = 1; m_iss_op = s_op; m_iss_data = s_data; end
        else      begin e_hr = 1; m_iss_op = h_op; m_iss_data = h_data; end
        m_last = pick; m_iss_id = pick; m_issue_at = cyc + 1;
        if (m_iss_op == OP_ADJ && m_iss_data[31:0] != 32'hFFFF_FFFF) begin
          m_adj_act = 1; m_arm_start = cyc + 2; m_wait_start = -1; m_free_at = INF;
        end else begin
          m_free_at = cyc + 2 + SETTLE;
          m_done_at = m_free_at; m_done_id = pick; m_done_err = 0;
        end
      end
    end
    check("h_ready", h_ready, e_hr);
    check("s_ready", s_ready, e_sr);
    check("busy", busy, e_busy);
    check("time_ld", time_ld, e_ld[0]);
    check("period_ld", period_ld, e_ld[1]);
    check("adj_ld", adj_ld, e_ld[2]);
    check("offset_ld", offset_ld, e_ld[3]);
    check("time_ns", time_ns, e_tns);
    check("time_sec", time_sec, e_tsec);
    check("period_in", period_in, e_per);
    check("adj_data", adj_data, e_adj);
    check("period_adj", period_adj, e_padj);
    check("off_ns", off_ns, e_ons);
    check("off_sec", off_sec, e_osec);
    check("done", done, e_done);
    if (e_done) begin
      check("done_id", done_id, e_did);
      check("done_err", done_err, e_derr);
    end
`ifdef RTC_CMD_ARB_STATS_EN
    check("stat_h", stat_h, 16'(m_sh));
    check("stat_s", stat_s, 16'(m_ss));
    check("stat_err", stat_e, 16'(m_se));
`endif
  end

  // ---------------- directed sequence ----------------
  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (n_done_seen < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    #2;
    check("done_count", n_done_seen, target);
  endtask

  task automatic one_cmd(input bit servo, input cmd_t c, input int budget);
    int tgt = n_done_seen + 1;
    if (servo) s_q.push_back(c);
    else       h_q.push_back(c);
    wait_done(tgt, budget);
  endtask

  initial begin
    int         tgt, gsz, k, n_before;
    logic [3:0] rr_exp = 4'b1010;

    repeat (3) @(posedge clk);
    #2;
    check("rst_period_in", period_in, 40'h8_0000_0000);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(posedge clk); #2;

    // Both requesters valid on the same cycle: H, S, H, S.
    tgt = n_done_seen + 4;
    grant_log.delete();
    h_q.push_back(mk(OP_TIME,   96'h0000_0012_3456_789A_BCDE_F012));
    s_q.push_back(mk(OP_TIME,   96'h0000_00AB_CDEF_0123_4567_89AB));
    h_q.push_back(mk(OP_PERIOD, 96'h0000_0000_0000_0006_4000_0000));
    s_q.push_back(mk(OP_OFFSET, 96'h0000_8000_0000_0042_0000_1234));
    wait_done(tgt, 100);
    check("rr_grants", grant_log.size(), 4);
    for (int i = 0; i < grant_log.size() && i < 4; i++)
      check($sformatf("rr_grant%0d", i), grant_log[i], rr_exp[i]);

    // Host PERIOD: done 5 cycles after grant.
    one_cmd(1'b0, mk(OP_PERIOD, {56'h0, 40'h7_FFFF_FF00}), 50);
    check("per_latency", last_done_cyc - last_grant_cyc, 5);
    check("per_value", period_in, 40'h7_FFFF_FF00);
    check("per_done_id", last_done_id, 1'b0);
    check("per_done_err", last_done_err, 1'b0);

    // Servo ADJ cnt=10 against the rtc model: 14 cycles grant to done.
    one_cmd(1'b1, mk(OP_ADJ, {24'h0, 40'h12_3456_789A, 32'd10}), 50);
    check("adj_latency", last_done_cyc - last_grant_cyc, 14);
    check("adj_done_id", last_done_id, 1'b1);
    check("adj_done_err", last_done_err, 1'b0);
    check("adj_data", adj_data, 32'd10);

    // ADJ no-op takes the settle path.
    one_cmd(1'b0, mk(OP_ADJ, {24'h0, 40'h00_0000_00AB, 32'hFFFF_FFFF}), 50);
    check("noop_latency", last_done_cyc - last_grant_cyc, 5);
    check("noop_done_err", last_done_err, 1'b0);

    // adj_ld_done stuck high: never arms.
    rtc_mode = 1;
    @(posedge clk); #2;
    one_cmd(1'b1, mk(OP_ADJ, {24'h0, 40'h00_0000_0001, 32'd5}), 50);
    check("arm_latency", last_done_cyc - last_grant_cyc, 6);
    check("arm_done_id", last_done_id, 1'b1);
    check("arm_done_err", last_done_err, 1'b1);

    // adj_ld_done stuck low: WAIT_DONE times out after 64 cycles.
    rtc_mode = 2;
    @(posedge clk); #2;
    one_cmd(1'b0, mk(OP_ADJ, {24'h0, 40'h00_0000_0002, 32'd7}), 120);
    check("tmo_latency", last_done_cyc - last_grant_cyc, 67);
    check("tmo_done_id", last_done_id, 1'b0);
    check("tmo_done_err", last_done_err, 1'b1);

    // Reset during WAIT_DONE: no done, outputs back to reset values.
    n_before = n_done_seen;
    gsz = grant_log.size();
    h_q.push_back(mk(OP_ADJ, {24'h0, 40'h00_0000_0003, 32'd3}));
    k = 0;
    while (grant_log.size() == gsz && k < 20) begin @(posedge clk); k++; end
    check("rst_mid_granted", grant_log.size(), gsz + 1);
    repeat (10) @(posedge clk);
    #2;
    check("rst_mid_busy_before", busy, 1'b1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_mid_no_done", n_done_seen, n_before);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_adj_data", adj_data, 32'd0);
    check("rst_mid_period", period_in, 40'h8_0000_0000);
    rst = 1'b0;
    rtc_mode = 0;
    @(posedge clk); #2;

    one_cmd(1'b0, mk(OP_OFFSET, {16'h0, 48'h8000_0000_1234, 32'h0555_AAAA}), 50);
    check("off_latency", last_done_cyc - last_grant_cyc, 5);
    check("off_sec_val", off_sec, 48'h8000_0000_1234);
    check("off_ns_val", off_ns, 32'h0555_AAAA);
    check("off_done_err", last_done_err, 1'b0);
`ifdef RTC_CMD_ARB_STATS_EN
    check("stat_h_final", stat_h, 16'd1);
    check("stat_s_final", stat_s, 16'd0);
    check("stat_err_final", stat_e, 16'd0);
`endif

    repeat (3) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (cycle %0d)", cyc);
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

endmodule
